// File: rtl/distance_bcd_converter.sv
// Turns the game controller's signed distance total into packed BCD for the odometer display.
// Each start-of-frame pulse clamps the sample, then runs a double-dabble conversion at one bit per clock.
module distance_bcd_converter #(
  parameter int DIGITS    = 6,
  parameter int BIN_W     = 20,
  parameter int MAX_VALUE = 999999
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startOfFrame,
  input  logic signed [31:0]    distance_drove,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  clamped,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
  localparam logic signed [31:0] MAX_S = MAX_VALUE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic signed [31:0]   latch_r;
  logic signed [31:0]   clamp_val_s;
  logic                 clamp_flag_s;
  logic                 flag_r;
  logic [BIN_W-1:0]     bin_r;
  logic [BCD_W-1:0]     scratch_r;
  logic [BCD_W-1:0]     adj_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [BCD_W-1:0]     bcd_r;
  logic                 valid_r;
  logic                 clamped_r;

  // Nibble-wise add-3 correction; each digit is adjusted independently, no carry between digits.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < DIGITS; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; pulses outside IDLE are deliberately ignored.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (startOfFrame) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD:    state_nxt_s = CONVERT;
      CONVERT: begin
        if (cnt_r == LAST_STEP) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CONVERT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Signed clamp of the latched sample into the displayable range.
  always_comb begin
    clamp_val_s  = latch_r;
    clamp_flag_s = 1'b0;
    if (latch_r < 32'sd0) begin
      clamp_val_s  = 32'sd0;
      clamp_flag_s = 1'b1;
    end else if (latch_r > MAX_S) begin
      clamp_val_s  = MAX_S;
      clamp_flag_s = 1'b1;
    end else begin
      clamp_val_s  = latch_r;
      clamp_flag_s = 1'b0;
    end
  end

  // Digit correction applied before each shift.
  always_comb begin
    adj_s = add3_nibbles(scratch_r);
  end

  // Conversion datapath and published result; bcd/clamped only change in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch_r   <= 32'sd0;
      flag_r    <= 1'b0;
      bin_r     <= '0;
      scratch_r <= '0;
      cnt_r     <= '0;
      bcd_r     <= '0;
      valid_r   <= 1'b0;
      clamped_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (startOfFrame) begin
            latch_r <= distance_drove;
          end
        end
        LOAD: begin
          bin_r     <= BIN_W'(clamp_val_s);
          flag_r    <= clamp_flag_s;
          scratch_r <= '0;
          cnt_r     <= '0;
        end
        CONVERT: begin
          scratch_r <= {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
          bin_r     <= {bin_r[BIN_W-2:0], 1'b0};
          cnt_r     <= cnt_r + 1'b1;
        end
        DONE: begin
          bcd_r     <= scratch_r;
          clamped_r <= flag_r;
          valid_r   <= 1'b1;
        end
        default: begin
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bcd       = bcd_r;
  assign bcd_valid = valid_r;
  assign clamped   = clamped_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_distance_bcd_converter.sv
// Scoreboard bench for distance_bcd_converter: stimulus pushes model results, a monitor pops on bcd_valid.
module tb_distance_bcd_converter;

  logic               clk;
  logic               reset;
  logic               startOfFrame;
  logic signed [31:0] distance_drove;
  logic [23:0]        bcd;
  logic               bcd_valid;
  logic               clamped;
  logic               busy;

  typedef struct {
    logic [23:0] bcd;
    logic        clamped;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   prev_valid = 1'b0;

  distance_bcd_converter #(.DIGITS(6), .BIN_W(20), .MAX_VALUE(999999)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .distance_drove(distance_drove),
    .bcd(bcd), .bcd_valid(bcd_valid), .clamped(clamped), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: clamp with plain integer compares, decimal digits by division.
  function automatic int clamp_val(input int d);
    if (d < 0) return 0;
    else if (d > 999999) return 999999;
    else return d;
  endfunction

  function automatic bit is_clamped(input int d);
    return (d < 0) || (d > 999999);
  endfunction

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Monitor: every bcd_valid must match the oldest pending expectation, with exact latency.
  always @(negedge clk) begin
    if (!reset) begin
      if (bcd_valid) begin
        if (prev_valid) check("valid_width", 64'd2, 64'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {40'd0, bcd}, 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("bcd", {40'd0, bcd}, {40'd0, e.bcd});
          check("clamped", {63'd0, clamped}, {63'd0, e.clamped});
          check("latency", 64'(cyc), 64'(e.cyc + 22));
        end
      end
      prev_valid = bcd_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic pulse(input int d, input bit accept);
    exp_t e;
    @(negedge clk); #1;
    distance_drove = d;
    startOfFrame   = 1'b1;
    if (accept) begin
      e.bcd     = to_bcd(clamp_val(d));
      e.clamped = is_clamped(d);
      e.cyc     = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk); #1;
    startOfFrame = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      check("wait_idle_timeout", 64'd0, 64'd1);
      exp_q.delete();
    end
  endtask

  task automatic frame(input int d);
    pulse(d, 1'b1);
    wait_idle();
  endtask

  initial begin
    reset          = 1'b1;
    startOfFrame   = 1'b0;
    distance_drove = 32'sd0;
    #23;
    check("rst_bcd", {40'd0, bcd}, 64'd0);
    check("rst_valid", {63'd0, bcd_valid}, 64'd0);
    check("rst_clamped", {63'd0, clamped}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); #1 reset = 1'b0;

    frame(123456);

    // Reset in the middle of CONVERT must wipe everything immediately.
    pulse(555, 1'b1);
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_bcd", {40'd0, bcd}, 64'd0);
    check("midrst_valid", {63'd0, bcd_valid}, 64'd0);
    check("midrst_clamped", {63'd0, clamped}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    repeat (30) @(negedge clk);
    check("no_valid_after_abort", {63'd0, bcd_valid}, 64'd0);
    frame(7);

    frame(0);
    frame(999999);
    frame(1000000);
    frame(-5);
    frame(32'sh7FFF_FFFF);
    frame(32'sh8000_0000);
    frame(1);

    // Second pulse while busy is dropped; a later pulse in IDLE converts it.
    pulse(42, 1'b1);
    repeat (4) @(negedge clk);
    pulse(77, 1'b0);
    wait_idle();
    frame(77);

    // Hold: no pulse, distance wiggles, outputs stay put.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      distance_drove = $urandom;
      #1;
      check("hold_bcd", {40'd0, bcd}, {40'd0, to_bcd(77)});
      check("hold_clamped", {63'd0, clamped}, 64'd0);
      check("hold_valid", {63'd0, bcd_valid}, 64'd0);
    end

    for (int n = 0; n < 40; n++) begin
      int d;
      int d2;
      case ($urandom_range(0, 3))
        0:       d = int'($urandom_range(0, 99));
        1:       d = int'($urandom_range(0, 999999));
        2:       d = int'($urandom_range(1000000, 32'h7FFF_FFFF));
        default: d = -int'($urandom_range(1, 32'h7FFF_FFFF));
      endcase
      pulse(d, 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        d2 = int'($urandom_range(0, 999999));
        repeat ($urandom_range(0, 15)) @(negedge clk);
        pulse(d2, 1'b0);
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
